// File: rtl/sram_arbiter.sv
// Two-master arbiter for one SRAM-like req/addr_ok/data_ok port.
// Data wins the address phase, grants are held until addr_ok, and responses follow an in-order owner FIFO.
module sram_arbiter #(
    parameter int DEPTH = 2
) (
    input  logic        clk,
    input  logic        resetn,

    input  logic        inst_req,
    input  logic        inst_wr,
    input  logic [1:0]  inst_size,
    input  logic [3:0]  inst_wstrb,
    input  logic [31:0] inst_addr,
    input  logic [31:0] inst_wdata,
    output logic        inst_addr_ok,
    output logic        inst_data_ok,
    output logic [31:0] inst_rdata,

    input  logic        data_req,
    input  logic        data_wr,
    input  logic [1:0]  data_size,
    input  logic [3:0]  data_wstrb,
    input  logic [31:0] data_addr,
    input  logic [31:0] data_wdata,
    output logic        data_addr_ok,
    output logic        data_data_ok,
    output logic [31:0] data_rdata,

    output logic        mem_req,
    output logic        mem_wr,
    output logic [1:0]  mem_size,
    output logic [3:0]  mem_wstrb,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic        mem_addr_ok,
    input  logic        mem_data_ok,
    input  logic [31:0] mem_rdata,

    output logic        busy
);
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = PW + 1;

    // Handshake: a master holds req and its fields stable until it sees addr_ok;
    // a transfer happens in the cycle where mem_req and mem_addr_ok are both high.
    typedef enum logic {
        LOCK_OPEN   = 1'b0,
        LOCK_HELD   = 1'b1
    } lock_state_t;

    lock_state_t       lock_state;
    logic              lock_owner;
    logic [DEPTH-1:0]  owner_q;
    logic [PW-1:0]     rd_ptr;
    logic [PW-1:0]     wr_ptr;
    logic [CW-1:0]     count;

    logic sel;
    logic sel_req;
    logic full;
    logic acc;
    logic pop;
    logic head;

    assign sel     = (lock_state == LOCK_HELD) ? lock_owner : data_req;
    assign sel_req = sel ? data_req : inst_req;
    assign full    = (count == CW'(DEPTH));
    // resetn gates the request path so nothing leaks out while reset is asserted
    assign mem_req = resetn & sel_req & ~full;
    assign acc     = mem_req & mem_addr_ok;
    assign pop     = mem_data_ok & (count != '0);
    assign head    = owner_q[rd_ptr];

    always_comb begin
        mem_wr    = 1'b0;
        mem_size  = 2'b00;
        mem_wstrb = 4'h0;
        mem_addr  = 32'h0;
        mem_wdata = 32'h0;
        if (mem_req) begin
            if (sel) begin
                mem_wr    = data_wr;
                mem_size  = data_size;
                mem_wstrb = data_wstrb;
                mem_addr  = data_addr;
                mem_wdata = data_wdata;
            end else begin
                mem_wr    = inst_wr;
                mem_size  = inst_size;
                mem_wstrb = inst_wstrb;
                mem_addr  = inst_addr;
                mem_wdata = inst_wdata;
            end
        end
    end

    assign inst_addr_ok = acc & ~sel;
    assign data_addr_ok = acc & sel;
    assign inst_data_ok = pop & ~head;
    assign data_data_ok = pop & head;
    assign inst_rdata   = inst_data_ok ? mem_rdata : 32'h0;
    assign data_rdata   = data_data_ok ? mem_rdata : 32'h0;
    assign busy         = (count != '0);

    // An offered-but-unaccepted request keeps the grant; a dropped request releases it.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            lock_state <= LOCK_OPEN;
            lock_owner <= 1'b0;
        end else if (mem_req && !mem_addr_ok) begin
            lock_state <= LOCK_HELD;
            lock_owner <= sel;
        end else begin
            lock_state <= LOCK_OPEN;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            owner_q <= '0;
            rd_ptr  <= '0;
            wr_ptr  <= '0;
            count   <= '0;
        end else begin
            if (acc) begin
                owner_q[wr_ptr] <= sel;
                wr_ptr          <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({acc, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end
endmodule
